app_inject_arbiter: RTL

//  Shares one NoC injection port (tx/credit/data) between N_SRC application-parser sources.
//  - Grants the port to one source at a time, round-robin.
//  - The grant is burst-atomic: it is held until the source's flagged last flit is accepted.
//  - Sits between the per-source application parsers and the task injector.
//  - Reports end-of-applications once every source has finished.

---
 rtl/app_inject_arbiter.sv | 109 ++++++++++
 1 files changed

// File: rtl/app_inject_arbiter.sv
// app_inject_arbiter: burst-atomic round-robin sharing of one NoC injection port among N_SRC sources.
// Define INJ_ARB_STATS_EN to add per-source saturating flit/burst counters with a selectable read port.
module app_inject_arbiter #(
    parameter int N_SRC = 4,
    parameter int FLIT_SIZE = 32
`ifdef INJ_ARB_STATS_EN
    , parameter int CNT_WIDTH = 32
`endif
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [N_SRC-1:0]           src_tx_i,
    input  logic [N_SRC-1:0]           src_last_i,
    input  logic [N_SRC*FLIT_SIZE-1:0] src_data_i,
    output logic [N_SRC-1:0]           src_credit_o,
    input  logic [N_SRC-1:0]           src_eoa_i,
    output logic                       tx_o,
    output logic [FLIT_SIZE-1:0]       data_o,
    input  logic                       credit_i,
    output logic [N_SRC-1:0]           grant_o,
    output logic                       busy_o,
    output logic                       eoa_o
`ifdef INJ_ARB_STATS_EN
    ,
    input  logic [(N_SRC > 1 ? $clog2(N_SRC) : 1)-1:0] stat_sel_i,
    output logic [CNT_WIDTH-1:0]       stat_flits_o,
    output logic [CNT_WIDTH-1:0]       stat_bursts_o
`endif
);
    localparam int IW = N_SRC > 1 ? $clog2(N_SRC) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   owner, owner_n, rr_ptr, rr_ptr_n, win;
    logic [N_SRC-1:0] grant_n;
    logic            found, xfer, done;

    always_comb begin
        win = '0;
        found = 1'b0;
        for (int i = 1; i <= N_SRC; i++) begin
            automatic int idx = (int'(rr_ptr) + i) % N_SRC;
            if (!found && src_tx_i[idx]) begin
                found = 1'b1;
                win = IW'(idx);
            end
        end
    end

    assign busy_o       = state == BUSY;
    assign tx_o         = busy_o & src_tx_i[owner];
    assign data_o       = busy_o ? src_data_i[int'(owner)*FLIT_SIZE +: FLIT_SIZE] : '0;
    assign src_credit_o = grant_o & {N_SRC{credit_i}};
    assign xfer         = tx_o & credit_i;
    assign done         = xfer & src_last_i[owner];

    always_comb begin
        state_n  = state;
        owner_n  = owner;
        rr_ptr_n = rr_ptr;
        grant_n  = grant_o;
        if (state == IDLE && found) begin
            state_n = BUSY;
            owner_n = win;
            grant_n = N_SRC'(1) << win;
        end else if (state == BUSY && done) begin
            state_n  = IDLE;
            rr_ptr_n = owner;
            grant_n  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            owner   <= '0;
            rr_ptr  <= IW'(N_SRC - 1);
            grant_o <= '0;
            eoa_o   <= 1'b0;
        end else begin
            state   <= state_n;
            owner   <= owner_n;
            rr_ptr  <= rr_ptr_n;
            grant_o <= grant_n;
            eoa_o   <= (&src_eoa_i) & (state == IDLE) & ~(|src_tx_i);
        end
    end

`ifdef INJ_ARB_STATS_EN
    logic [CNT_WIDTH-1:0] flits [N_SRC];
    logic [CNT_WIDTH-1:0] bursts [N_SRC];

    always_ff @(posedge clk_i) begin
        for (int s = 0; s < N_SRC; s++) begin
            if (rst_i) begin
                flits[s]  <= '0;
                bursts[s] <= '0;
            end else if (xfer && int'(owner) == s) begin
                if (~&flits[s]) flits[s] <= flits[s] + CNT_WIDTH'(1);
                if (done && ~&bursts[s]) bursts[s] <= bursts[s] + CNT_WIDTH'(1);
            end
        end
    end

    assign stat_flits_o  = int'(stat_sel_i) < N_SRC ? flits[stat_sel_i] : '0;
    assign stat_bursts_o = int'(stat_sel_i) < N_SRC ? bursts[stat_sel_i] : '0;
`endif
endmodule
